// File: rtl/sd_cic_decim.sv
// -----------------------------------------------------------------------------
// sd_cic_decim
//   Third-order CIC decimator. It takes the 2-bit ternary bitstream from the
//   sigma-delta modulator and produces signed PCM samples. The decimation
//   ratio is R = 2^DECIM_LOG2. Each output is offered on a valid/ready port
//   backed by a single-entry holding register. A sample that arrives while the
//   previous one is still unconsumed is dropped and flagged.
//
//   Optional feature (macro SD_CIC_OVERRUN_CNT_EN):
//     Adds the overrun_cnt port, an 8-bit saturating count of dropped samples.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   sd_in      bitstream: 00 = -1, 01/10 = 0, 11 = +1
//   sd_valid   sd_in is accepted on this edge; low cycles are ignored
//   out_data   signed decimated sample (OUT_W bits)
//   out_valid  out_data holds an unconsumed sample
//   out_ready  consumer takes the sample when out_valid && out_ready
//   overrun    sticky: a sample was dropped
//   overrun_cnt  (optional) saturating count of dropped samples
// -----------------------------------------------------------------------------
module sd_cic_decim #(
  parameter int DECIM_LOG2 = 6,
  parameter int OUT_W      = 3*DECIM_LOG2+2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       sd_in,
  input  logic             sd_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SD_CIC_OVERRUN_CNT_EN
  output logic [7:0]       overrun_cnt,
`endif
  output logic             overrun
);

  logic [OUT_W-1:0]      x;
  logic [OUT_W-1:0]      i1_q, i2_q, i3_q, i1_d, i2_d, i3_d;
  logic [OUT_W-1:0]      d1_q, d2_q, d3_q;
  logic [OUT_W-1:0]      c1_q, c2_q, c3_q;
  logic [DECIM_LOG2-1:0] ph_q;
  logic [3:0]            vld_pipe_q;
  logic                  strb_d;
  logic [OUT_W-1:0]      out_data_q;
  logic                  out_valid_q, overrun_q;
`ifdef SD_CIC_OVERRUN_CNT_EN
  logic [7:0]            ovr_cnt_q;
`endif

  // Ternary input, sign-extended to the full datapath width.
  always_comb begin
    x = '0;
    if (sd_in == 2'b11)      x = OUT_W'(1);
    else if (sd_in == 2'b00) x = '1;
  end

  // The integrators are chained combinationally, so I3 already contains the
  // sample accepted on the same edge. Modulo arithmetic is intended. The
  // combs cancel the wrap-around.
  always_comb begin
    i1_d = i1_q + x;
    i2_d = i2_q + i1_d;
    i3_d = i3_q + i2_d;
  end

  // The strobe fires on the edge that accepts the last sample of the period.
  assign strb_d = sd_valid && (&ph_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i1_q       <= '0;
      i2_q       <= '0;
      i3_q       <= '0;
      ph_q       <= '0;
      vld_pipe_q <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      d3_q       <= '0;
      c1_q       <= '0;
      c2_q       <= '0;
      c3_q       <= '0;
    end else begin
      if (sd_valid) begin
        i1_q <= i1_d;
        i2_q <= i2_d;
        i3_q <= i3_d;
        ph_q <= ph_q + 1'b1;    // R is a power of two, so it wraps naturally
      end
      vld_pipe_q <= {vld_pipe_q[2:0], strb_d};
      if (vld_pipe_q[0]) begin
        c1_q <= i3_q - d1_q;
        d1_q <= i3_q;
      end
      if (vld_pipe_q[1]) begin
        c2_q <= c1_q - d2_q;
        d2_q <= c1_q;
      end
      if (vld_pipe_q[2]) begin
        c3_q <= c2_q - d3_q;
        d3_q <= c2_q;
      end
    end
  end

  // Single-entry output holder. A new sample may replace the old one on the
  // same edge the old one is consumed. Otherwise the new sample is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SD_CIC_OVERRUN_CNT_EN
      ovr_cnt_q   <= '0;
`endif
    end else if (vld_pipe_q[3]) begin
      if (!out_valid_q || out_ready) begin
        out_data_q  <= c3_q;
        out_valid_q <= 1'b1;
      end else begin
        overrun_q <= 1'b1;
`ifdef SD_CIC_OVERRUN_CNT_EN
        if (ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
`endif
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
`ifdef SD_CIC_OVERRUN_CNT_EN
  assign overrun_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_sd_cic_decim.sv
// Directed bench for sd_cic_decim at R = 64 (OUT_W = 20).
// The expected values are the cubic CIC outputs for a constant input after
// reset: 45760, 220480, and then 262144 from the third output onward.
module tb_sd_cic_decim;
  localparam int L = 6;
  localparam int W = 3*L+2;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   sd_in;
  logic         sd_valid;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         overrun;
`ifdef SD_CIC_OVERRUN_CNT_EN
  logic [7:0]   overrun_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sd_cic_decim #(.DECIM_LOG2(L)) dut (
    .clk(clk), .reset(rst), .sd_in(sd_in), .sd_valid(sd_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef SD_CIC_OVERRUN_CNT_EN
    .overrun_cnt(overrun_cnt),
`endif
    .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, $signed(obs), obs,
             $signed(exp), exp);
    end
  endtask

  // Runs negedge to negedge until out_valid is seen. Inputs are driven on the
  // same negedges. gap toggles sd_valid every cycle. alt toggles sd_in between
  // 01 and 10. n returns the number of cycles waited.
  task automatic wait_out(input string tag, input bit gap, input bit alt,
                          output int n, output logic [31:0] d);
    n = 0;
    d = 'x;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      n++;
      if (gap) sd_valid = ~sd_valid;
      if (alt) sd_in = (sd_in == 2'b01) ? 2'b10 : 2'b01;
      if (out_valid) begin
        d = $signed(out_data);
        return;
      end
    end
    chk({tag, "_timeout"}, 32'(n), 32'd0);
  endtask

  task automatic do_reset(input logic [1:0] s);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sd_in    = s;
    sd_valid = 1'b1;
    rst      = 1'b0;
  endtask

  int          n;
  logic [31:0] d;

  initial begin
    rst = 1'b1; sd_in = 2'b11; sd_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_data",    32'(out_data),  32'd0);
    chk("rst_valid",   32'(out_valid), 32'd0);
    chk("rst_overrun", 32'(overrun),   32'd0);
`ifdef SD_CIC_OVERRUN_CNT_EN
    chk("rst_cnt", 32'(overrun_cnt), 32'd0);
`endif

    // DC +1, continuous. Integrators wrap well before the third output.
    do_reset(2'b11);
    wait_out("p1", 0, 0, n, d);
    chk("p_lat",  32'(n), 32'd68);
    chk("p_o1",   d, 32'd45760);
    wait_out("p2", 0, 0, n, d);
    chk("p_per2", 32'(n), 32'd64);
    chk("p_o2",   d, 32'd220480);
    for (int k = 0; k < 6; k++) begin
      wait_out("p3", 0, 0, n, d);
      chk("p_per", 32'(n), 32'd64);
      chk("p_ss",  d, 32'd262144);
    end
    chk("p_ovr", 32'(overrun), 32'd0);

    // DC -1.
    do_reset(2'b00);
    wait_out("m1", 0, 0, n, d);
    chk("m_o1", d, -32'sd45760);
    wait_out("m2", 0, 0, n, d);
    chk("m_o2", d, -32'sd220480);
    for (int k = 0; k < 2; k++) begin
      wait_out("m3", 0, 0, n, d);
      chk("m_ss", d, -32'sd262144);
    end

    // Zero input, alternating between the two zero encodings.
    do_reset(2'b01);
    for (int k = 0; k < 3; k++) begin
      wait_out("z", 0, 1, n, d);
      chk("z_out", d, 32'd0);
    end

    // Gapped input: sd_valid toggles every cycle.
    do_reset(2'b11);
    wait_out("g1", 1, 0, n, d);
    chk("g_lat", 32'(n), 32'd131);
    chk("g_o1",  d, 32'd45760);
    wait_out("g2", 1, 0, n, d);
    chk("g_per", 32'(n), 32'd128);
    chk("g_o2",  d, 32'd220480);
    wait_out("g3", 1, 0, n, d);
    chk("g_per3", 32'(n), 32'd128);
    chk("g_ss",   d, 32'd262144);

    // Backpressure: the second sample is dropped. The third lands on the
    // same edge that consumes the first.
    do_reset(2'b11);
    out_ready = 1'b0;
    wait_out("b1", 0, 0, n, d);
    chk("b_o1", d, 32'd45760);
    repeat (64) @(negedge clk);
    chk("b_hold",  32'($signed(out_data)), 32'd45760);
    chk("b_valid", 32'(out_valid), 32'd1);
    chk("b_ovr",   32'(overrun),   32'd1);
    repeat (63) @(negedge clk);
    chk("b_pre_ovr", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("b_swap",    32'($signed(out_data)), 32'd262144);
    chk("b_swap_v",  32'(out_valid), 32'd1);
`ifdef SD_CIC_OVERRUN_CNT_EN
    chk("b_cnt", 32'(overrun_cnt), 32'd1);
`endif
    @(negedge clk);
    chk("b_drain_v", 32'(out_valid), 32'd0);
    chk("b_sticky",  32'(overrun),   32'd1);

    // Reset mid-period, applied asynchronously between clock edges.
    do_reset(2'b11);
    wait_out("r1", 0, 0, n, d);
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("r_data", 32'(out_data), 32'd0);
    chk("r_ovr",  32'(overrun),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_out("r2", 0, 0, n, d);
    chk("r_lat", 32'(n), 32'd68);
    chk("r_o1",  d, 32'd45760);
    wait_out("r3", 0, 0, n, d);
    chk("r_o2",  d, 32'd220480);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
